// File: rtl/rbe_binconv_sequencer_pkg.sv
// Shared types and defaults for the BinConv job sequencer: state encoding,
// latched job configuration and the status flags presented to the controller.
package rbe_binconv_sequencer_pkg;

    localparam int unsigned KIN_W        = 16;
    localparam int unsigned TILE_W       = 16;
    localparam int unsigned QW_W         = 4;
    localparam int unsigned DEF_MAX_QW   = 8;
    localparam int unsigned DEF_PIPE_LAT = 3;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CLEAR,
        SEQ_COMPUTE,
        SEQ_DRAIN,
        SEQ_OUTPUT,
        SEQ_DONE
    } rbe_seq_state_e;

    typedef struct packed {
        logic              fs;
        logic [QW_W-1:0]   qw;
        logic [KIN_W-1:0]  n_kin;
        logic [TILE_W-1:0] n_tiles;
    } ctrl_binconv_seq_t;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            err;
        logic [QW_W-1:0] wbit;
    } flags_binconv_seq_t;

    // A job needs at least one bit-plane, one channel chunk and one tile.
    function automatic logic cfg_is_legal(input ctrl_binconv_seq_t c, input int unsigned max_qw);
        return (c.qw != '0) && (32'(c.qw) <= max_qw) && (c.n_kin != '0) && (c.n_tiles != '0);
    endfunction

endpackage

// File: rtl/rbe_binconv_sequencer_nested_counter.sv
// Three-level bit/kin/tile loop counter; each level wraps at its limit and
// reports when it sits on its last value.
module rbe_binconv_sequencer_nested_counter
    import rbe_binconv_sequencer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_all_i,
    input  logic              clr_inner_i,
    input  logic              step_i,
    input  logic              tile_step_i,
    input  logic [QW_W-1:0]   bit_lim_i,
    input  logic [KIN_W-1:0]  kin_lim_i,
    input  logic [TILE_W-1:0] tile_lim_i,
    output logic [QW_W-1:0]   bit_o,
    output logic              bit_last_o,
    output logic              kin_last_o,
    output logic              tile_last_o
);

    logic [QW_W-1:0]   bit_q;
    logic [KIN_W-1:0]  kin_q;
    logic [TILE_W-1:0] tile_q;

    assign bit_o       = bit_q;
    assign bit_last_o  = (bit_q == bit_lim_i);
    assign kin_last_o  = (kin_q == kin_lim_i);
    assign tile_last_o = (tile_q == tile_lim_i);

    // Bit-plane is the fastest level; kin advances only when the bit level wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_all_i) begin
            bit_q  <= '0;
            kin_q  <= '0;
            tile_q <= '0;
        end else begin
            if (clr_inner_i) begin
                bit_q <= '0;
                kin_q <= '0;
            end else if (step_i) begin
                if (bit_last_o) begin
                    bit_q <= '0;
                    kin_q <= kin_last_o ? '0 : kin_q + KIN_W'(1);
                end else begin
                    bit_q <= bit_q + QW_W'(1);
                end
            end
            if (tile_step_i) begin
                tile_q <= tile_last_o ? '0 : tile_q + TILE_W'(1);
            end
        end
    end

endmodule

// File: rtl/rbe_binconv_sequencer.sv
// Sequences one binary-convolution job: per tile clear, step every
// (kin chunk x bit-plane) beat, drain the array pipeline, hand results downstream.
module rbe_binconv_sequencer
    import rbe_binconv_sequencer_pkg::*;
#(
    parameter int unsigned MAX_QW   = DEF_MAX_QW,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              fs_i,
    input  logic [QW_W-1:0]   qw_i,
    input  logic [KIN_W-1:0]  n_kin_i,
    input  logic [TILE_W-1:0] n_tiles_i,
    input  logic              act_valid_i,
    output logic              act_ready_o,
    input  logic              wgt_valid_i,
    output logic              wgt_ready_o,
    output logic              array_enable_o,
    output logic              array_clear_o,
    output logic              fs_o,
    output logic [QW_W-1:0]   wbit_o,
    output logic              pres_valid_o,
    input  logic              pres_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    rbe_seq_state_e     state_q, state_d;
    ctrl_binconv_seq_t  cfg_q, cfg_in;
    flags_binconv_seq_t flags;
    logic [DRAIN_W-1:0] drain_q;
    logic busy_q, done_q, err_q, clear_q, enable_q, pvalid_q;
    logic cfg_legal, beat;
    logic cnt_clr_all, cnt_clr_inner, cnt_step, cnt_tile_step;
    logic [QW_W-1:0] bit_cnt;
    logic bit_last, kin_last, tile_last;

    assign cfg_in    = '{fs: fs_i, qw: qw_i, n_kin: n_kin_i, n_tiles: n_tiles_i};
    assign cfg_legal = cfg_is_legal(cfg_in, MAX_QW);
    assign beat      = (state_q == SEQ_COMPUTE) && act_valid_i && wgt_valid_i;

    rbe_binconv_sequencer_nested_counter u_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_all_i   (cnt_clr_all),
        .clr_inner_i (cnt_clr_inner),
        .step_i      (cnt_step),
        .tile_step_i (cnt_tile_step),
        .bit_lim_i   (cfg_q.qw - QW_W'(1)),
        .kin_lim_i   (cfg_q.n_kin - KIN_W'(1)),
        .tile_lim_i  (cfg_q.n_tiles - TILE_W'(1)),
        .bit_o       (bit_cnt),
        .bit_last_o  (bit_last),
        .kin_last_o  (kin_last),
        .tile_last_o (tile_last)
    );

    always_comb begin
        state_d       = state_q;
        cnt_clr_all   = 1'b0;
        cnt_clr_inner = 1'b0;
        cnt_step      = 1'b0;
        cnt_tile_step = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    if (cfg_legal) begin
                        state_d     = SEQ_CLEAR;
                        cnt_clr_all = 1'b1;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_CLEAR: begin
                cnt_clr_inner = 1'b1;
                state_d       = SEQ_COMPUTE;
            end
            SEQ_COMPUTE: begin
                if (beat) begin
                    cnt_step = 1'b1;
                    if (bit_last && kin_last) begin
                        state_d = (PIPE_LAT == 0) ? SEQ_OUTPUT : SEQ_DRAIN;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = SEQ_OUTPUT;
                end
            end
            SEQ_OUTPUT: begin
                if (pres_ready_i) begin
                    if (tile_last) begin
                        state_d = SEQ_DONE;
                    end else begin
                        cnt_tile_step = 1'b1;
                        state_d       = SEQ_CLEAR;
                    end
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SEQ_IDLE;
            cfg_q    <= '0;
            drain_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clear_q  <= 1'b0;
            enable_q <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == SEQ_IDLE) && start_i) begin
                cfg_q <= cfg_in;
                err_q <= !cfg_legal;
            end
            drain_q  <= (state_q == SEQ_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
            busy_q   <= (state_d != SEQ_IDLE);
            done_q   <= (state_d == SEQ_DONE);
            clear_q  <= (state_d == SEQ_CLEAR);
            enable_q <= (state_d inside {SEQ_CLEAR, SEQ_COMPUTE, SEQ_DRAIN});
            pvalid_q <= (state_d == SEQ_OUTPUT);
        end
    end

    assign flags = '{busy: busy_q, done: done_q, err: err_q, wbit: bit_cnt};

    // Activations are reused across all bit-planes, so they are consumed on the last one.
    assign wgt_ready_o    = beat;
    assign act_ready_o    = beat && bit_last;
    assign array_enable_o = enable_q;
    assign array_clear_o  = clear_q;
    assign fs_o           = cfg_q.fs;
    assign wbit_o         = flags.wbit;
    assign pres_valid_o   = pvalid_q;
    assign busy_o         = flags.busy;
    assign done_o         = flags.done;
    assign err_o          = flags.err;

endmodule

// File: tb/tb_rbe_binconv_sequencer.sv
// Scoreboard bench for the BinConv sequencer: jobs push expected beat/result/done
// events, a forked monitor pops and compares them as the DUT produces them.
module tb_rbe_binconv_sequencer;
    import rbe_binconv_sequencer_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i, start_i, fs_i, act_valid_i, wgt_valid_i, pres_ready_i;
    logic [QW_W-1:0]   qw_i, wbit_o;
    logic [KIN_W-1:0]  n_kin_i;
    logic [TILE_W-1:0] n_tiles_i;
    logic act_ready_o, wgt_ready_o, array_enable_o, array_clear_o, fs_o;
    logic pres_valid_o, busy_o, done_o, err_o;

    typedef enum int {EV_BEAT, EV_PRES, EV_DONE} evKind_e;
    typedef struct {
        evKind_e kind;
        int      wbit;
        int      act;
        int      err;
    } expEvent_t;

    expEvent_t expQ[$];
    int checks = 0;
    int failures = 0;
    int wgtCnt, actCnt, clearCnt, doneCnt;
    int validMode, stallLen, stallCnt, jobCycles, firstPresCycle, stalledCycles, presCycles, timedOut;
    logic v;

    always #5 clk_i = ~clk_i;

    rbe_binconv_sequencer #(.MAX_QW(8), .PIPE_LAT(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .fs_i           (fs_i),
        .qw_i           (qw_i),
        .n_kin_i        (n_kin_i),
        .n_tiles_i      (n_tiles_i),
        .act_valid_i    (act_valid_i),
        .act_ready_o    (act_ready_o),
        .wgt_valid_i    (wgt_valid_i),
        .wgt_ready_o    (wgt_ready_o),
        .array_enable_o (array_enable_o),
        .array_clear_o  (array_clear_o),
        .fs_o           (fs_o),
        .wbit_o         (wbit_o),
        .pres_valid_o   (pres_valid_o),
        .pres_ready_i   (pres_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int outputsWord();
        return int'({busy_o, done_o, err_o, fs_o, wbit_o, pres_valid_o,
                     array_enable_o, array_clear_o, act_ready_o, wgt_ready_o});
    endfunction

    task automatic popExpect(input evKind_e kind, output expEvent_t e, output bit ok);
        ok = (expQ.size() != 0);
        checkOutput("sbEventExpected", int'(ok), 1);
        if (ok) begin
            e = expQ.pop_front();
            checkOutput("sbEventKind", int'(kind), int'(e.kind));
            ok = (e.kind == kind);
        end
    endtask

    task automatic monitor();
        expEvent_t e;
        bit ok;
        forever begin
            @(negedge clk_i);
            if (rst_i) continue;
            if (array_clear_o) clearCnt++;
            if (act_ready_o) checkOutput("actNeedsWgtReady", int'(wgt_ready_o), 1);
            if (wgt_ready_o) begin
                wgtCnt++;
                if (act_ready_o) actCnt++;
                checkOutput("beatNeedsValids", int'(act_valid_i & wgt_valid_i), 1);
                popExpect(EV_BEAT, e, ok);
                if (ok) begin
                    checkOutput("beatWbit", int'(wbit_o), e.wbit);
                    checkOutput("beatActReady", int'(act_ready_o), e.act);
                end
            end
            if (pres_valid_o && pres_ready_i) popExpect(EV_PRES, e, ok);
            if (done_o) begin
                doneCnt++;
                popExpect(EV_DONE, e, ok);
                if (ok) checkOutput("doneErr", int'(err_o), e.err);
            end
        end
    endtask

    // Called at posedge+1; leaves start_i high across exactly one active edge.
    task automatic applyStimulus(input int fs, input int qw, input int nkin, input int ntiles);
        expEvent_t e;
        bit legal;
        legal = (qw >= 1) && (qw <= 8) && (nkin >= 1) && (ntiles >= 1);
        if (legal) begin
            for (int t = 0; t < ntiles; t++) begin
                for (int k = 0; k < nkin; k++) begin
                    for (int b = 0; b < qw; b++) begin
                        e = '{kind: EV_BEAT, wbit: b, act: int'(b == qw - 1), err: 0};
                        expQ.push_back(e);
                    end
                end
                e = '{kind: EV_PRES, wbit: 0, act: 0, err: 0};
                expQ.push_back(e);
            end
        end
        e = '{kind: EV_DONE, wbit: 0, act: 0, err: int'(!legal)};
        expQ.push_back(e);
        wgtCnt = 0; actCnt = 0; clearCnt = 0; doneCnt = 0;
        fs_i = fs[0]; qw_i = QW_W'(qw); n_kin_i = KIN_W'(nkin); n_tiles_i = TILE_W'(ntiles);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic waitJob(input int budget);
        jobCycles = 1; firstPresCycle = 0; stalledCycles = 0; presCycles = 0;
        timedOut = 1; stallCnt = 0; v = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pres_valid_o) begin
                presCycles++;
                if (firstPresCycle == 0) firstPresCycle = jobCycles;
                if (stallCnt < stallLen) begin
                    pres_ready_i = 1'b0;
                    stallCnt++;
                    stalledCycles++;
                    checkOutput("stallEnableLow", int'(array_enable_o), 0);
                end else begin
                    pres_ready_i = 1'b1;
                    stallCnt = 0;
                end
            end else begin
                pres_ready_i = 1'b1;
            end
            if (validMode != 0) begin
                v = ~v;
                act_valid_i = v;
                wgt_valid_i = v;
            end
            if (done_o) begin
                timedOut = 0;
                break;
            end
            @(posedge clk_i); #1;
            jobCycles++;
        end
        checkOutput("jobTimeout", timedOut, 0);
    endtask

    task automatic endJob(input string tag, input int expWgt, input int expAct, input int expClr);
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        checkOutput({tag, "_wgtReadyCount"}, wgtCnt, expWgt);
        checkOutput({tag, "_actReadyCount"}, actCnt, expAct);
        checkOutput({tag, "_clearCount"}, clearCnt, expClr);
        checkOutput({tag, "_doneCount"}, doneCnt, 1);
        checkOutput({tag, "_queueLeft"}, expQ.size(), 0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; fs_i = 1'b0; qw_i = '0; n_kin_i = '0; n_tiles_i = '0;
        act_valid_i = 1'b1; wgt_valid_i = 1'b1; pres_ready_i = 1'b1;
        validMode = 0; stallLen = 0;
        wgtCnt = 0; actCnt = 0; clearCnt = 0; doneCnt = 0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("resetOutputs", outputsWord(), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        $display("[TB] basic job qw=2 n_kin=3 n_tiles=1");
        applyStimulus(0, 2, 3, 1);
        checkOutput("basicBusy", int'(busy_o), 1);
        waitJob(200);
        checkOutput("basicDoneCycle", jobCycles, 12);
        checkOutput("basicFirstPres", firstPresCycle, 11);
        endJob("basic", 6, 3, 1);

        $display("[TB] toggling valids");
        validMode = 1;
        applyStimulus(0, 2, 3, 1);
        waitJob(200);
        endJob("toggle", 6, 3, 1);
        validMode = 0; act_valid_i = 1'b1; wgt_valid_i = 1'b1;

        $display("[TB] three tiles with output backpressure");
        stallLen = 5;
        applyStimulus(1, 1, 2, 3);
        waitJob(300);
        checkOutput("stallCycles", stalledCycles, 15);
        checkOutput("stallPresCycles", presCycles, 18);
        endJob("stall", 6, 6, 3);
        stallLen = 0;

        $display("[TB] illegal configurations");
        applyStimulus(0, 0, 3, 1);
        waitJob(20);
        checkOutput("qw0DoneCycle", jobCycles, 1);
        checkOutput("qw0Err", int'(err_o), 1);
        endJob("qw0", 0, 0, 0);
        checkOutput("errSticky", int'(err_o), 1);
        applyStimulus(0, 2, 0, 1);
        waitJob(20);
        checkOutput("kin0DoneCycle", jobCycles, 1);
        endJob("kin0", 0, 0, 0);
        applyStimulus(0, 9, 1, 1);
        waitJob(20);
        checkOutput("qw9DoneCycle", jobCycles, 1);
        endJob("qw9", 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        checkOutput("errClearedOnLegal", int'(err_o), 0);
        waitJob(50);
        checkOutput("legalDoneCycle", jobCycles, 7);
        endJob("legal", 1, 1, 1);

        $display("[TB] reset during compute");
        applyStimulus(1, 3, 4, 2);
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        checkOutput("preResetBusy", int'(busy_o), 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("midResetOutputs", outputsWord(), 0);
        rst_i = 1'b0;
        expQ.delete();
        doneCnt = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        checkOutput("noDoneAfterReset", doneCnt, 0);
        applyStimulus(0, 2, 3, 1);
        waitJob(200);
        checkOutput("postResetDoneCycle", jobCycles, 12);
        endJob("postReset", 6, 3, 1);

        $display("[TB] start pulsed while busy");
        applyStimulus(1, 2, 2, 2);
        @(posedge clk_i); #1;
        start_i = 1'b1; fs_i = 1'b0; qw_i = '0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        checkOutput("busyStartFsHeld", int'(fs_o), 1);
        waitJob(200);
        checkOutput("busyStartFsAtDone", int'(fs_o), 1);
        endJob("busyStart", 8, 4, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rbe_binconv_sequencer.md
Name: rbe_binconv_sequencer

Overview:
- Sequences one binary-convolution job on the BinConv array.
- Per output spatial tile: clears the column accumulators, then steps the array through every (input-channel chunk × weight bit-plane) beat. It then waits for the array pipeline to drain and hands the column partial results downstream.
- Sits between the RBE top-level controller (start/config) and the array, the activation/weight streamers, and the output stage.

Parameters:
- KIN_W, 16: width of the input-channel-chunk count (chunks of TP channels).
- TILE_W, 16: width of the spatial tile count.
- QW_W, 4: width of the weight-bit count field.
- MAX_QW, 8: maximum legal weight bit-planes.
- PIPE_LAT, 3: cycles from the last accepted beat until the array column results are stable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  job start pulse; sampled only in IDLE.
- fs_i  in  1  filter size select: 0 = fs1, 1 = fs3.
- qw_i  in  QW_W  number of weight bit-planes, legal 1..MAX_QW.
- n_kin_i  in  KIN_W  input-channel chunks per tile, ≥1.
- n_tiles_i  in  TILE_W  spatial tiles per job, ≥1.
- act_valid_i  in  1  AND of all activation stream valids.
- act_ready_o  out  1  activation consume (broadcast ready).
- wgt_valid_i  in  1  AND of all weight stream valids.
- wgt_ready_o  out  1  weight consume.
- array_enable_o  out  1  array enable.
- array_clear_o  out  1  array accumulator clear.
- fs_o  out  1  latched filter size, driven to the array control.
- wbit_o  out  QW_W  current weight bit index, for the shift/scale inside the blocks.
- pres_valid_o  out  1  column results valid.
- pres_ready_i  in  1  downstream accepts results.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- err_o  out  1  illegal config seen at last start; sticky until next accepted start.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, all counters 0, config registers 0.
  - All outputs 0.
  - Takes effect mid-job too: the job is abandoned, no done_o.
- Config latching: in IDLE, when start_i=1, fs_i/qw_i/n_kin_i/n_tiles_i are latched. The input pins are ignored at all other times.
- Illegal config: qw=0, qw>MAX_QW, n_kin=0 or n_tiles=0.
  - On an illegal config → DONE directly, err_o=1.
  - On a legal start, err_o is cleared.
- States and transitions:
  - IDLE: busy_o=0. start_i → CLEAR, or DONE if the config is illegal.
  - CLEAR: one cycle; array_clear_o=1, array_enable_o=1; bit and kin counters reset to 0 → COMPUTE.
  - COMPUTE:
    - array_enable_o=1.
    - A beat fires when act_valid_i & wgt_valid_i.
    - wgt_ready_o = beat.
    - act_ready_o = beat & (bit==qw-1): activations are reused across all bit-planes.
    - No readies are asserted without a beat.
    - On a beat: bit++. When bit==qw-1 it wraps to 0 and kin++.
    - When the beat has kin==n_kin-1 and bit==qw-1 → DRAIN.
    - Beats per tile = qw·n_kin exactly.
  - DRAIN: array_enable_o=1; counts PIPE_LAT cycles → OUTPUT. With PIPE_LAT=0 the state is skipped.
  - OUTPUT:
    - pres_valid_o=1; held until pres_ready_i, with array_enable_o=0 (accumulators frozen).
    - On handshake: if tile==n_tiles-1 → DONE; else tile++ → CLEAR.
    - pres_ready_i asserted in the same cycle pres_valid_o rises completes the handshake in that cycle.
  - DONE: one cycle; done_o=1 → IDLE. busy_o=1 in every state except IDLE.
- Outputs: wbit_o = bit counter (registered); fs_o = latched fs.
- start_i outside IDLE is ignored.
- Counter widths:
  - Counters have the widths of their respective fields.
  - Maximum counts (2^KIN_W−1, 2^TILE_W−1) are supported without overflow; comparisons are equality against config−1.
- Latency: start to first possible beat = 2 cycles (CLEAR, then COMPUTE).

Decomposition:
- Add to rbe_package:
  - rbe_seq_state_e enum (IDLE, CLEAR, COMPUTE, DRAIN, OUTPUT, DONE).
  - ctrl_binconv_seq_t struct {fs, qw, n_kin, n_tiles}.
  - flags_binconv_seq_t struct {busy, done, err, wbit}.
- One sub-module is natural: rbe_nested_counter, a 3-level (bit/kin/tile) counter with per-level limit and last flags.

Test Plan:
- qw=2, n_kin=3, n_tiles=1, valids always 1, pres_ready_i=1 → 6 wgt_ready_o pulses, 3 act_ready_o pulses (on bit=1); 1 clear; pres_valid_o 3 cycles after the last beat; done_o at cycle 12 after start.
- Same config, valids toggling every other cycle → still exactly 6/3 readies; wbit_o sequence 0,1,0,1,0,1.
- n_tiles=3, pres_ready_i held low 5 cycles per tile → pres_valid_o stable for 5 cycles, array_enable_o=0 meanwhile; 3 clears; done_o once.
- start with qw=0 (then, separately, n_kin=0) → done_o next cycle, err_o=1, no readies; a following legal start clears err_o.
- rst_i asserted mid-COMPUTE → next cycle all outputs 0, busy_o=0; a new start runs a full correct job.
- start_i pulsed while busy, with fs_i changed → ignored; fs_o keeps its latched value until done.
